// File: rtl/light_panel_input.sv
// Push-button and pattern-switch front end: synchronize, debounce, classify presses.
// Debounced outputs follow a clean raw edge by DEBOUNCE_CYC+2 cycles; no backpressure, pulses are one cycle.
module light_panel_input #(
    parameter int DEBOUNCE_CYC = 2000000,
    parameter int LONG_CYC     = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic [2:0] switch,
    output logic       btn_level,
    output logic       btn_short,
    output logic       btn_long,
    output logic [2:0] sw_value,
    output logic       sw_load,
    output logic       run
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = $clog2(LONG_CYC + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);

    typedef enum logic [1:0] {IDLE, HELD, LONG, REL} state_t;

    logic          btn_s1, btn_s2;
    logic [2:0]    sw_s1, sw_s2;
    logic [DW-1:0] btn_cnt, sw_cnt;
    logic          sw_upd;
    logic [HW-1:0] hold_cnt;
    state_t        state, state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            sw_s1  <= 3'b000;
            sw_s2  <= 3'b000;
        end else begin
            btn_s1 <= button;
            btn_s2 <= btn_s1;
            sw_s1  <= switch;
            sw_s2  <= sw_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_cnt   <= '0;
            btn_level <= 1'b0;
        end else if (btn_s2 == btn_level) begin
            btn_cnt <= '0;
        end else if (btn_cnt == DB_LAST) begin
            btn_level <= btn_s2;
            btn_cnt   <= '0;
        end else begin
            btn_cnt <= btn_cnt + DW'(1);
        end
    end

    // The word only counts as stable when the next synchronized sample matches the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_cnt   <= '0;
            sw_value <= 3'b000;
            sw_upd   <= 1'b0;
            sw_load  <= 1'b0;
        end else begin
            sw_upd  <= 1'b0;
            sw_load <= sw_upd;
            if (sw_s2 == sw_value || sw_s2 != sw_s1) begin
                sw_cnt <= '0;
            end else if (sw_cnt == DB_LAST) begin
                sw_value <= sw_s2;
                sw_cnt   <= '0;
                sw_upd   <= 1'b1;
            end else begin
                sw_cnt <= sw_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            hold_cnt <= '0;
        end else if (btn_level && hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        btn_short = 1'b0;
        btn_long  = 1'b0;
        case (state)
            IDLE: begin
                if (btn_level) state_nxt = HELD;
            end
            HELD: begin
                if (!btn_level) begin
                    state_nxt = REL;
                end else if (hold_cnt == LONG_LAST) begin
                    state_nxt = LONG;
                    btn_long  = 1'b1;
                end
            end
            LONG: begin
                if (!btn_level) state_nxt = IDLE;
            end
            REL: begin
                btn_short = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || btn_long) begin
            run <= 1'b0;
        end else if (btn_short) begin
            run <= ~run;
        end
    end

endmodule

// File: tb/tb_light_panel_input.sv
// Directed bench for light_panel_input with DEBOUNCE_CYC=4, LONG_CYC=20.
module tb_light_panel_input;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic [2:0] switch;
    logic       btn_level, btn_short, btn_long, sw_load, run;
    logic [2:0] sw_value;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    light_panel_input #(.DEBOUNCE_CYC(4), .LONG_CYC(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .button    (button),
        .switch    (switch),
        .btn_level (btn_level),
        .btn_short (btn_short),
        .btn_long  (btn_long),
        .sw_value  (sw_value),
        .sw_load   (sw_load),
        .run       (run)
    );

    typedef struct {
        logic       btn;
        logic [2:0] sw;
        logic       lvl;
        logic       sh;
        logic       lg;
        logic [2:0] swv;
        logic       ld;
        logic       run;
    } vec_t;

    vec_t tbl[20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic lvl, input logic sh, input logic lg,
                           input logic [2:0] swv, input logic ld, input logic rn);
        chk({name, ".level"}, 32'(btn_level), 32'(lvl));
        chk({name, ".short"}, 32'(btn_short), 32'(sh));
        chk({name, ".long"},  32'(btn_long),  32'(lg));
        chk({name, ".sw_value"}, 32'(sw_value), 32'(swv));
        chk({name, ".sw_load"},  32'(sw_load),  32'(ld));
        chk({name, ".run"}, 32'(run), 32'(rn));
    endtask

    initial begin
        int nlong, nshort, nload, long_at;

        // Short press: button high steps 0..9; level 6..15; short at 17; run set from 18.
        for (int i = 0; i < 20; i++) begin
            tbl[i] = '{btn: (i < 10), sw: 3'b000, lvl: (i >= 6 && i <= 15), sh: (i == 17),
                       lg: 1'b0, swv: 3'b000, ld: 1'b0, run: (i >= 18)};
        end

        rst = 1'b1; button = 1'b1; switch = 3'b111;
        repeat (3) tick();
        chk_all("reset", 0, 0, 0, 3'b000, 0, 0);
        rst = 1'b0; button = 1'b0; switch = 3'b000;
        repeat (8) tick();
        chk_all("idle", 0, 0, 0, 3'b000, 0, 0);

        for (int i = 0; i < 20; i++) begin
            button = tbl[i].btn;
            switch = tbl[i].sw;
            tick();
            chk_all($sformatf("short_press[%0d]", i), tbl[i].lvl, tbl[i].sh, tbl[i].lg,
                    tbl[i].swv, tbl[i].ld, tbl[i].run);
        end
        repeat (4) tick();

        // Bounce 1,1,1,0,1,1,1 never accumulates four differing cycles.
        for (int i = 0; i < 16; i++) begin
            button = (i < 7 && i != 3);
            tick();
            chk($sformatf("bounce[%0d].level", i), 32'(btn_level), 0);
            chk($sformatf("bounce[%0d].pulse", i), 32'(btn_short | btn_long), 0);
        end
        chk("bounce.run", 32'(run), 1);
        repeat (4) tick();

        // Long hold: level at 6, btn_long exactly at 26, run cleared, no short on release.
        nlong = 0; nshort = 0; long_at = -1;
        for (int i = 0; i < 56; i++) begin
            button = (i < 40);
            tick();
            if (btn_long) begin nlong++; long_at = i; end
            if (btn_short) nshort++;
            if (i == 5)  chk("long.level_pre", 32'(btn_level), 0);
            if (i == 6)  chk("long.level_rise", 32'(btn_level), 1);
            if (i == 26) chk("long.run_before", 32'(run), 1);
            if (i == 27) chk("long.run_cleared", 32'(run), 0);
        end
        chk("long.count", 32'(nlong), 1);
        chk("long.when", 32'(long_at), 26);
        chk("long.no_short", 32'(nshort), 0);
        chk("long.run_end", 32'(run), 0);

        // Switch 000->101: value at 6, load only at 7.
        for (int i = 0; i < 11; i++) begin
            switch = 3'b101;
            tick();
            if (i == 5) chk("sw.value_pre", 32'(sw_value), 32'h0);
            if (i == 6) chk("sw.value", 32'(sw_value), 32'h5);
            chk($sformatf("sw.load[%0d]", i), 32'(sw_load), 32'(i == 7));
        end
        nload = 0;
        for (int i = 0; i < 30; i++) begin
            switch = (i < 20 && ((i / 2) % 2 == 0)) ? 3'b010 : 3'b101;
            tick();
            if (sw_load) nload++;
        end
        chk("sw_toggle.loads", 32'(nload), 0);
        chk("sw_toggle.value", 32'(sw_value), 32'h5);

        // Release and switch change on the same edge: short and load coincide at 17.
        for (int i = 0; i < 20; i++) begin
            button = (i < 10);
            switch = (i >= 10) ? 3'b011 : 3'b101;
            tick();
            if (i == 16) chk("coinc.sw_value", 32'(sw_value), 32'h3);
            if (i == 17) begin
                chk("coinc.short", 32'(btn_short), 1);
                chk("coinc.load", 32'(sw_load), 1);
            end
            if (i == 18) begin
                chk("coinc.run", 32'(run), 1);
                chk("coinc.pulses_gone", 32'(btn_short | sw_load), 0);
            end
        end
        repeat (4) tick();

        // Reset during HELD (hold count 10 at step 17), button and switches stay up.
        nlong = 0; nshort = 0;
        for (int i = 0; i < 30; i++) begin
            button = 1'b1;
            rst = (i == 18 || i == 19);
            tick();
            if (btn_long) nlong++;
            if (btn_short) nshort++;
            if (i == 17) chk("rst.level_held", 32'(btn_level), 1);
            if (i == 18 || i == 19) chk_all($sformatf("rst.during[%0d]", i), 0, 0, 0, 3'b000, 0, 0);
            if (i >= 20 && i <= 25) chk($sformatf("rst.level_low[%0d]", i), 32'(btn_level), 0);
            if (i == 26) begin
                chk("rst.level_rise", 32'(btn_level), 1);
                chk("rst.sw_value", 32'(sw_value), 32'h3);
                chk("rst.sw_load_early", 32'(sw_load), 0);
            end
            if (i == 27) chk("rst.sw_load", 32'(sw_load), 1);
        end
        chk("rst.no_pulses", 32'(nlong + nshort), 0);
        button = 1'b0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/light_panel_input.md
LIGHT_PANEL_INPUT -- requirements
Module: light_panel_input

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYC, default 2000000, meaning the consecutive stable cycles required to accept an input change (20 ms at 100 MHz; legal minimum 2).
REQ-002 The block SHALL have parameter LONG_CYC, default 100000000, meaning the debounced hold cycles that qualify a long press (1 s at 100 MHz; SHALL exceed DEBOUNCE_CYC).
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port button  input  1  raw asynchronous push-button, high = pressed.
REQ-006 The block SHALL have port switch  input  3  raw asynchronous pattern switches.
REQ-007 The block SHALL have port btn_level  output  1  debounced button level.
REQ-008 The block SHALL have port btn_short  output  1  one-cycle pulse on release of a press shorter than LONG_CYC.
REQ-009 The block SHALL have port btn_long  output  1  one-cycle pulse when a hold reaches LONG_CYC.
REQ-010 The block SHALL have port sw_value  output  3  debounced switch value.
REQ-011 The block SHALL have port sw_load  output  1  one-cycle pulse when sw_value changes.
REQ-012 The block SHALL have port run  output  1  light-sequencer enable level.

Function
REQ-013 button and each switch bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each debounced signal SHALL use its own counter, cleared whenever the synchronized input equals the debounced value.
REQ-015 A debounced value SHALL take the synchronized value on the edge at which that input has differed for DEBOUNCE_CYC consecutive cycles; any intermediate match SHALL restart the count.
REQ-016 The switch bits SHALL be debounced as one 3-bit word: the counter advances only while the synchronized word differs from sw_value and is unchanged since the previous cycle.
REQ-017 Raw-edge to debounced-output latency SHALL be exactly DEBOUNCE_CYC+2 cycles for a clean, bounce-free input.
REQ-018 The button FSM SHALL have four states: IDLE, HELD, LONG, and a release-handling path back to IDLE.
REQ-019 IDLE->HELD SHALL occur on the btn_level rising edge; the hold counter SHALL clear to 0 on this transition.
REQ-020 In HELD, the hold counter SHALL increment each cycle that btn_level is high.
REQ-021 At hold count LONG_CYC-1 the FSM SHALL move HELD->LONG and pulse btn_long for one cycle.
REQ-022 HELD->IDLE on btn_level falling SHALL pulse btn_short for one cycle.
REQ-023 LONG->IDLE on btn_level falling SHALL produce no pulse.
REQ-024 The FSM SHALL produce at most one btn_long per press.
REQ-025 The hold counter SHALL saturate and never wrap; its width SHALL be ceil(log2(LONG_CYC+1)).
REQ-026 run SHALL toggle on each btn_short and clear to 0 on btn_long.
REQ-027 btn_short and btn_long SHALL never assert in the same cycle.
REQ-028 sw_load SHALL pulse in the cycle after sw_value updates.
REQ-029 sw_load SHALL be independent of button activity; coincident sw_load and btn_short/btn_long pulses SHALL both be issued.
REQ-030 A bounce shorter than DEBOUNCE_CYC cycles SHALL produce no output change and no pulse.

Reset
REQ-031 While rst is high at a clock edge, the following SHALL be 0: synchronizer flops, debounce counters, hold counter, btn_level, btn_short, btn_long, sw_value, sw_load, run; the FSM SHALL be in IDLE.
REQ-032 Reset asserted mid-press SHALL abort the press with no pulse.
REQ-033 If button is still high after reset releases, the block SHALL treat it as a new press after DEBOUNCE_CYC+2 cycles.
REQ-034 After reset releases, switches held at a nonzero value SHALL produce sw_value update and a sw_load pulse after DEBOUNCE_CYC+2(+1) cycles.

Verification (DEBOUNCE_CYC=4, LONG_CYC=20)
REQ-035 The bench SHALL cover: button high at edge k for 10 cycles, then low -> btn_level rises at k+6; btn_short single pulse at fall+6+1; run 0->1.
REQ-036 The bench SHALL cover: button high 3 cycles, low 1, high 3 (bounce) -> btn_level stays 0, no pulses, run unchanged.
REQ-037 The bench SHALL cover: button held 40 cycles with run=1 -> exactly one btn_long, 20 cycles after btn_level rise; run->0; no btn_short on release.
REQ-038 The bench SHALL cover: switch 000->101 stable -> sw_value=101 at k+6, sw_load one pulse at k+7; switch toggling every 2 cycles -> no sw_load.
REQ-039 The bench SHALL cover: rst pulsed during HELD (count 10) -> all outputs 0; button still high -> new btn_level rise 6 cycles after rst falls.
REQ-040 The bench SHALL cover: short-press release and switch change aligned to the same cycle -> btn_short and sw_load both asserted in the same cycle.
